mxu_postproc: RTL

- Post-processing stage directly downstream of the systolic matmul wrapper.
- After the wrapper writes its N×N int32 result tile to memory and pulses done, control starts this block on that tile.
- Per element: adds a per-column bias, applies a rounding arithmetic right shift with signed saturation, and applies an optional ReLU.
- Writes the tile back to memory over the same fixed-latency, single-word memory port protocol the MXU uses.

---
 rtl/mxu_postproc.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mxu_postproc.sv
// Post-processing stage for an MXU result tile: per-column bias add, rounding
// arithmetic right shift with signed saturation, optional ReLU, written back in order.
module mxu_postproc #(
  parameter int N             = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 13,
  parameter int MEM_LATENCY   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     relu_en,
  input  logic [4:0]               shift,
  input  logic [ADDRESS_WIDTH-1:0] base_addr_in,
  input  logic [ADDRESS_WIDTH-1:0] base_addr_bias,
  input  logic [ADDRESS_WIDTH-1:0] base_addr_out,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0]    mem_req_data,
  input  logic [DATA_WIDTH-1:0]    mem_resp_data,
  output logic                     mem_read_en,
  output logic                     mem_write_en
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDRESS_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int EW = (N > 1) ? $clog2(N * N) : 1;
  localparam int TW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [CW-1:0] LAST_COL  = CW'(N - 1);
  localparam logic [EW-1:0] LAST_ELEM = EW'(N * N - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(MEM_LATENCY - 1);

  localparam logic signed [DW+1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [DW+1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE,
    S_BIAS_REQ,
    S_BIAS_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_COMPUTE,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          relu_q, relu_d;
  logic [4:0]    shift_q, shift_d;
  logic [AW-1:0] base_in_q, base_in_d;
  logic [AW-1:0] base_bias_q, base_bias_d;
  logic [AW-1:0] base_out_q, base_out_d;
  logic [EW-1:0] elem_idx_q, elem_idx_d;
  logic [CW-1:0] bias_idx_q, bias_idx_d;
  logic [CW-1:0] col_q, col_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] x_q, x_d;
  logic [DW-1:0] y_q, y_d;
  logic [DW-1:0] bias_q [N];
  logic [DW-1:0] bias_d [N];
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rd_en_q, rd_en_d;
  logic          wr_en_q, wr_en_d;

  // Datapath: two guard bits keep bias add plus rounding increment overflow-free.
  logic signed [DW+1:0] rnd_c, sum_c, shr_c;
  logic [DW-1:0]        b_sel_c, sat_c, res_c;

  always_comb begin
    b_sel_c = bias_q[col_q];
    rnd_c   = '0;
    if (shift_q != 5'd0) begin
      rnd_c = (DW+2)'(1) << (shift_q - 5'd1);
    end
    sum_c = {{2{x_q[DW-1]}}, x_q} + {{2{b_sel_c[DW-1]}}, b_sel_c} + rnd_c;
    shr_c = sum_c >>> shift_q;
    if (shr_c > SAT_MAX) begin
      sat_c = SAT_MAX[DW-1:0];
    end else if (shr_c < SAT_MIN) begin
      sat_c = SAT_MIN[DW-1:0];
    end else begin
      sat_c = shr_c[DW-1:0];
    end
    res_c = (relu_q && sat_c[DW-1]) ? '0 : sat_c;
  end

  always_comb begin
    state_d     = state_q;
    relu_d      = relu_q;
    shift_d     = shift_q;
    base_in_d   = base_in_q;
    base_bias_d = base_bias_q;
    base_out_d  = base_out_q;
    elem_idx_d  = elem_idx_q;
    bias_idx_d  = bias_idx_q;
    col_d       = col_q;
    timer_d     = timer_q;
    x_d         = x_q;
    y_d         = y_q;
    bias_d      = bias_q;
    done_d      = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          relu_d      = relu_en;
          shift_d     = shift;
          base_in_d   = base_addr_in;
          base_bias_d = base_addr_bias;
          base_out_d  = base_addr_out;
          elem_idx_d  = '0;
          bias_idx_d  = '0;
          col_d       = '0;
          state_d     = S_BIAS_REQ;
        end
      end
      S_BIAS_REQ: begin
        rd_en_d = 1'b1;
        addr_d  = base_bias_q + AW'(bias_idx_q);
        timer_d = '0;
        state_d = S_BIAS_WAIT;
      end
      S_BIAS_WAIT: begin
        if (timer_q == LAST_TICK) begin
          bias_d[bias_idx_q] = mem_resp_data;
          if (bias_idx_q == LAST_COL) begin
            state_d = S_RD_REQ;
          end else begin
            bias_idx_d = bias_idx_q + 1'b1;
            state_d    = S_BIAS_REQ;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RD_REQ: begin
        rd_en_d = 1'b1;
        addr_d  = base_in_q + AW'(elem_idx_q);
        timer_d = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (timer_q == LAST_TICK) begin
          x_d     = mem_resp_data;
          state_d = S_COMPUTE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_COMPUTE: begin
        y_d     = res_c;
        state_d = S_WR_REQ;
      end
      S_WR_REQ: begin
        wr_en_d = 1'b1;
        addr_d  = base_out_q + AW'(elem_idx_q);
        wdata_d = y_q;
        timer_d = '0;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (timer_q == LAST_TICK) begin
          if (elem_idx_q == LAST_ELEM) begin
            state_d = S_DONE;
          end else begin
            elem_idx_d = elem_idx_q + 1'b1;
            col_d      = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
            state_d    = S_RD_REQ;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d     = 1'b1;
        elem_idx_d = '0;
        bias_idx_d = '0;
        col_d      = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      relu_q      <= 1'b0;
      shift_q     <= '0;
      base_in_q   <= '0;
      base_bias_q <= '0;
      base_out_q  <= '0;
      elem_idx_q  <= '0;
      bias_idx_q  <= '0;
      col_q       <= '0;
      timer_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      relu_q      <= relu_d;
      shift_q     <= shift_d;
      base_in_q   <= base_in_d;
      base_bias_q <= base_bias_d;
      base_out_q  <= base_out_d;
      elem_idx_q  <= elem_idx_d;
      bias_idx_q  <= bias_idx_d;
      col_q       <= col_d;
      timer_q     <= timer_d;
      x_q         <= x_d;
      y_q         <= y_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_bias
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        bias_q[gi] <= '0;
      end else begin
        bias_q[gi] <= bias_d[gi];
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_req_addr = addr_q;
  assign mem_req_data = wdata_q;
  assign mem_read_en  = rd_en_q;
  assign mem_write_en = wr_en_q;

endmodule
